// File: rtl/otter_pkg.sv
// Shared OTTER MCU types for the fetch-stage program counter.
//   pc_src_t   : next-PC select codes (6 and 7 are deliberately unnamed/illegal)
//   pc_fault_t : fault cause reported by the PC sequencer
//   pc_state_t : PC sequencer run/fault state
package otter_pkg;

  typedef enum logic [2:0] {
    PC_SRC_PC4    = 3'd0,
    PC_SRC_JALR   = 3'd1,
    PC_SRC_BRANCH = 3'd2,
    PC_SRC_JAL    = 3'd3,
    PC_SRC_MTVEC  = 3'd4,
    PC_SRC_MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    FAULT_NONE        = 2'd0,
    FAULT_ILLEGAL_SEL = 2'd1,
    FAULT_MISALIGN    = 2'd2
  } pc_fault_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the control unit (master) and the PC sequencer (slave).
//   master drives : pc_write, pc_source, jalr, branch, jal, mtvec, mepc, fault_clr
//   slave drives  : pc, pc_plus4, fault, fault_cause, fault_addr
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            pc_write;
  logic [2:0]      pc_source;
  logic [XLEN-1:0] jalr;
  logic [XLEN-1:0] branch;
  logic [XLEN-1:0] jal;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            fault_clr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fault;
  logic [1:0]      fault_cause;
  logic [XLEN-1:0] fault_addr;

  modport master (
    output pc_write, pc_source, jalr, branch, jal, mtvec, mepc, fault_clr,
    input  pc, pc_plus4, fault, fault_cause, fault_addr
  );

  modport slave (
    input  pc_write, pc_source, jalr, branch, jal, mtvec, mepc, fault_clr,
    output pc, pc_plus4, fault, fault_cause, fault_addr
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational 6-way next-PC selector with illegal select-code decode.
//   sel         : pc_source code (0..5 legal, 6/7 illegal)
//   pc_plus4, jalr, branch, jal, mtvec, mepc : candidate targets
//   next        : selected target (0 when the code is illegal)
//   sel_illegal : high for codes 6 and 7
module pc_next_sel
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] next,
  output logic            sel_illegal
);

  always_comb begin
    next        = '0;
    sel_illegal = 1'b0;
    case (sel)
      PC_SRC_PC4:    next = pc_plus4;
      PC_SRC_JALR:   next = jalr;
      PC_SRC_BRANCH: next = branch;
      PC_SRC_JAL:    next = jal;
      PC_SRC_MTVEC:  next = mtvec;
      PC_SRC_MEPC:   next = mepc;
      default:       sel_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// OTTER fetch-stage program counter: owns the PC register, computes PC+4,
// selects the next PC and traps illegal select codes / misaligned targets.
//   CLK, RST : rising-edge clock, asynchronous active-high reset
//   bus      : pc_sequencer_if.slave (write/select/targets/fault_clr in,
//              pc/pc_plus4/fault/fault_cause/fault_addr out)
// Build option: PC_MISALIGN_TRAP_EN -- when defined, a target with nonzero
// low bits raises a misalign fault; otherwise the low bits are cleared.
module pc_sequencer
  import otter_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input logic              CLK,
  input logic              RST,
  pc_sequencer_if.slave    bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("pc_sequencer: XLEN must be 32 or 64");
  end
  if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
    $error("pc_sequencer: RESET_VEC must be 4-byte aligned");
  end

  localparam logic [XLEN-1:0] FOUR       = {{(XLEN-3){1'b0}}, 3'd4};
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  pc_state_t       state_q, state_d;
  pc_fault_t       cause_q, cause_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next;
  logic            sel_illegal;

  // Wraps modulo 2^XLEN; a wrapped value is a legal, aligned target.
  assign pc_plus4 = pc_q + FOUR;

  pc_next_sel #(.XLEN(XLEN)) u_sel (
    .sel         (bus.pc_source),
    .pc_plus4    (pc_plus4),
    .jalr        (bus.jalr),
    .branch      (bus.branch),
    .jal         (bus.jal),
    .mtvec       (bus.mtvec),
    .mepc        (bus.mepc),
    .next        (next),
    .sel_illegal (sel_illegal)
  );

  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_RUN: begin
        if (bus.pc_write) begin
          if (sel_illegal) begin
            state_d = ST_FAULT;
            cause_d = FAULT_ILLEGAL_SEL;
            addr_d  = pc_q;
          end else begin
`ifdef PC_MISALIGN_TRAP_EN
            if (next[1:0] != 2'b00) begin
              state_d = ST_FAULT;
              cause_d = FAULT_MISALIGN;
              addr_d  = next;
            end else begin
              pc_d = next;
            end
`else
            pc_d = next & ALIGN_MASK;
`endif
          end
        end
      end
      ST_FAULT: begin
        // Acknowledge beats any concurrent write; fault_addr is kept.
        if (bus.fault_clr) begin
          pc_d    = bus.mtvec & ALIGN_MASK;
          state_d = ST_RUN;
          cause_d = FAULT_NONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_VEC;
      addr_q  <= '0;
      state_q <= ST_RUN;
      cause_q <= FAULT_NONE;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.fault_cause = cause_q;
  assign bus.fault_addr  = addr_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the OTTER MCU fetch stage. It replaces the stand-alone combinational next-PC selector. It owns the PC register, computes PC+4, and selects among six next-PC sources, adding the trap vector and the exception return address. It also detects illegal select codes and misaligned targets, and holds a fault state until the control unit acknowledges it.

## Interface
- `XLEN`, 32: address/data width in bits; must be 32 or 64.
- `RESET_VEC`, 0: PC value after reset; must be 4-byte aligned.
- `CLK`  in  1: rising-edge clock.
- `RST`  in  1: asynchronous, active-high reset.
- `pc_write`  in  1: load the selected next PC at this edge.
- `pc_source`  in  3: 0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc; 6 and 7 are illegal.
- `jalr`, `branch`, `jal`, `mtvec`, `mepc`  in  XLEN each: candidate targets.
- `fault_clr`  in  1: control-unit acknowledge of a pending fault.
- `pc`  out  XLEN: current PC (registered).
- `pc_plus4`  out  XLEN: `pc + 4`, combinational from `pc`.
- `fault`  out  1: high while in FAULT state.
- `fault_cause`  out  2: 0 none, 1 illegal select, 2 misaligned target.
- `fault_addr`  out  XLEN: offending address captured at fault entry.

## Operation
- There are two states, RUN and FAULT. Reset enters RUN with `pc`=`RESET_VEC`, `fault`=0, `fault_cause`=0 and `fault_addr`=0.
- RUN with `pc_write`=0: all registers hold.
- RUN with `pc_write`=1 and `pc_source` in 0..5: `next` = the selected input.
  - If `next[1:0]`≠0 (see Configuration), go to FAULT. Set `fault_cause`=2 and `fault_addr`=`next`. `pc` holds.
  - Otherwise `pc` <= `next`.
- RUN with `pc_write`=1 and `pc_source` 6 or 7: go to FAULT. Set `fault_cause`=1 and `fault_addr`=current `pc`. `pc` holds.
- FAULT: `pc_write` is ignored and `pc` holds.
  - On `fault_clr`=1: `pc` <= `mtvec & ~3`, state returns to RUN, and `fault`/`fault_cause` clear to 0.
  - `fault_addr` keeps its value until the next fault.
- `fault_clr` in RUN has no effect.
- When `fault_clr` and `pc_write` are both high in FAULT, the clear wins and the write is discarded.
- Arithmetic: `pc_plus4` wraps modulo 2^XLEN, so `pc`=all-ones−3 gives 0. A wrapped value is a legal target.
- Source 0 never raises a misaligned fault, because `pc` is always aligned.

## Timing
- `pc`, `fault`, `fault_cause` and `fault_addr` are registered and change only on the rising edge of `CLK`, or asynchronously on `RST`.
- Next-PC latency is 1 cycle: the write sampled at edge N is visible on `pc` after edge N.
- Fault entry: `fault` rises after the same edge that would have loaded `pc`.
- Fault exit: `fault` falls, and `pc`=trap vector, one edge after `fault_clr` is sampled high.
- `pc_plus4` settles combinationally within the same cycle as `pc`.
- `RST` asserted mid-fault or mid-write forces the reset values immediately. No pending state survives reset.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined: misaligned targets raise FAULT with cause 2, as described above.
- `PC_MISALIGN_TRAP_EN` undefined:
  - No misaligned check. `next[1:0]` is forced to 0 and loaded normally.
  - `fault_cause` never takes the value 2.
  - The illegal-select fault remains.

## Structure
- Shared package `otter_pkg` holds:
  - `pc_src_t` enum (PC_SRC_PC4, PC_SRC_JALR, PC_SRC_BRANCH, PC_SRC_JAL, PC_SRC_MTVEC, PC_SRC_MEPC).
  - `pc_fault_t` enum (FAULT_NONE, FAULT_ILLEGAL_SEL, FAULT_MISALIGN).
  - The `pc_state_t` enum.
- Sub-module `pc_next_sel`: the combinational 6-way selector plus illegal-code decode. It exposes `next` and `sel_illegal`.
- Elaboration-time assertion that `RESET_VEC[1:0]`==0.

## Test plan
- Reset → `pc`=`RESET_VEC`; one write with source 0 → `pc`=`RESET_VEC`+4, `pc_plus4`=`RESET_VEC`+8.
- Sources 1..5 loaded with 0x100, 0x200, 0x300, 0x400, 0x500, each written once → `pc` follows the selected value with 1-cycle latency.
- `pc_source`=6 at `pc`=0x40 → FAULT, cause 1, `fault_addr`=0x40. A following `pc_write` is ignored. `fault_clr` with `mtvec`=0x800 → `pc`=0x800 and `fault`=0.
- `jalr`=0x102 selected, macro on → FAULT, cause 2, `fault_addr`=0x102, `pc` unchanged. Macro off → `pc`=0x100 with no fault.
- `pc`=0xFFFF_FFFC (XLEN=32) with source 0 → `pc`=0 and no fault.
- `RST` pulsed while in FAULT → state RUN, `pc`=`RESET_VEC`, all fault outputs 0.
